// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit sitting in EX, stalling the pipe until done.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplies; division stays iterative.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  input  logic            i_ex_hold,
  output logic            o_stall_req,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  // state | meaning
  // IDLE  | waiting for an M instruction in EX
  // BUSY  | one radix-2 iteration per cycle, counter 31..0
  // DONE  | result valid; held while ex_hold
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic            r_neg_q;
  logic            r_neg_r;

  logic            w_sgn1;
  logic            w_sgn2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_sgn1 = i_rs1[XLEN-1] & ((i_func3 == F_MULH) || (i_func3 == F_MULHSU) ||
                                   (i_func3 == F_DIV)  || (i_func3 == F_REM));
  assign w_sgn2 = i_rs2[XLEN-1] & ((i_func3 == F_MULH) || (i_func3 == F_DIV) ||
                                   (i_func3 == F_REM));
  assign w_mag1 = w_sgn1 ? -i_rs1 : i_rs1;
  assign w_mag2 = w_sgn2 ? -i_rs2 : i_rs2;

  assign w_div_zero = i_func3[2] & (i_rs2 == '0);
  assign w_div_ovf  = ((i_func3 == F_DIV) || (i_func3 == F_REM)) &&
                      (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended operands; the low 2*XLEN bits of the product are exact for every MUL* form.
  logic [2*XLEN-1:0] w_fa;
  logic [2*XLEN-1:0] w_fb;
  logic [2*XLEN-1:0] w_fprod;
  assign w_fa    = {{XLEN{w_sgn1}}, i_rs1};
  assign w_fb    = {{XLEN{w_sgn2}}, i_rs2};
  assign w_fprod = w_fa * w_fb;
  assign w_fast  = w_div_zero | w_div_ovf | ~i_func3[2];
`else
  assign w_fast  = w_div_zero | w_div_ovf;
`endif

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = i_func3[1] ? i_rs1 : '1;
    else if (w_div_ovf)
      w_fast_res = i_func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
    else if (!i_func3[2])
      w_fast_res = (i_func3 == F_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`endif
  end

  // Divide step: {r_hi, r_a} shifts left, quotient bits enter at r_a[0].
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_hi_div;
  logic [XLEN-1:0] w_a_div;
  assign w_rem_sh = {r_hi, r_a[XLEN-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_diff   = w_rem_sh[XLEN-1:0] - r_b;
  assign w_hi_div = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
  assign w_a_div  = {r_a[XLEN-2:0], w_ge};

  // Multiply step: {r_hi, r_a} shifts right, multiplier bits leave at r_a[0].
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_hi_mul;
  logic [XLEN-1:0]   w_a_mul;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  assign w_sum    = {1'b0, r_hi} + (r_a[0] ? {1'b0, r_b} : '0);
  assign w_hi_mul = w_sum[XLEN:1];
  assign w_a_mul  = {w_sum[0], r_a[XLEN-1:1]};
  assign w_prod   = {w_hi_mul, w_a_mul};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;

  logic [XLEN-1:0] w_final;
  always_comb begin
    w_final = '0;
    case (r_op)
      F_MUL:                     w_final = w_prod_s[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = w_prod_s[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             w_final = r_neg_q ? -w_a_div : w_a_div;
      default:                   w_final = r_neg_r ? -w_hi_div : w_hi_div;
    endcase
  end

  assign o_stall_req = i_start & ~i_flush & (r_state != S_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op    <= i_func3;
            r_a     <= w_mag1;
            r_b     <= w_mag2;
            r_hi    <= '0;
            r_neg_q <= w_sgn1 ^ w_sgn2;
            r_neg_r <= w_sgn1;
            if (w_fast) begin
              r_state  <= S_DONE;
              r_cnt    <= '0;
              o_done   <= 1'b1;
              o_result <= w_fast_res;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= 5'd31;
            end
          end
        end
        S_BUSY: begin
          r_a  <= r_op[2] ? w_a_div  : w_a_mul;
          r_hi <= r_op[2] ? w_hi_div : w_hi_mul;
          if (r_cnt == '0) begin
            r_state  <= S_DONE;
            o_done   <= 1'b1;
            o_result <= w_final;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DONE: begin
          if (!i_ex_hold) begin
            r_state <= S_IDLE;
            o_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
